// File: rtl/seven_seg_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seven_seg_scanner                                             |
// | Purpose  : Multiplexed 7-segment scanner with blanking guard, brightness |
// |            window, hex decode and frame-synchronous input shadowing.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_W       = 4,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [SLOT_W-1:0]       bright,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int SLOTS = 2 ** SLOT_W;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SLOT_W:0]   BLANK     = (SLOT_W + 1)'(BLANK_CYCLES);
  localparam logic [SLOT_W:0]   MAX_ON    = (SLOT_W + 1)'(SLOTS - BLANK_CYCLES);

  logic [SLOT_W-1:0]       slot_cnt;
  logic [IDX_W-1:0]        digit_idx;
  logic [4*NUM_DIGITS-1:0] digits_sh;
  logic [NUM_DIGITS-1:0]   dp_sh;
  logic [NUM_DIGITS-1:0]   en_sh;
  logic [SLOT_W-1:0]       bright_sh;

  logic                    eof;
  logic [SLOT_W:0]         slot_ext;
  logic [SLOT_W:0]         on_time;
  logic [SLOT_W:0]         window_end;
  logic                    past_blank;
  logic                    in_window;
  logic [3:0]              cur_nib;
  logic                    cur_en;
  logic                    cur_dp;
  logic [NUM_DIGITS-1:0]   lit;

  function automatic logic [6:0] decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign eof        = (slot_cnt == SLOT_LAST) && (digit_idx == IDX_LAST);
  assign slot_ext   = {1'b0, slot_cnt};
  assign on_time    = ({1'b0, bright_sh} > MAX_ON) ? MAX_ON : {1'b0, bright_sh};
  assign window_end = BLANK + on_time;

  // With no guard the window opens at slot_cnt 0, so the lower bound vanishes.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign past_blank = 1'b1;
    end else begin : g_blank
      assign past_blank = (slot_ext >= BLANK);
    end
  endgenerate

  assign in_window = past_blank && (slot_ext < window_end);

  always_comb begin
    cur_nib = 4'h0;
    cur_en  = 1'b0;
    cur_dp  = 1'b0;
    lit     = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx == IDX_W'(k)) begin
        cur_nib = digits_sh[4*k +: 4];
        cur_en  = en_sh[k];
        cur_dp  = dp_sh[k];
        lit[k]  = en_sh[k] && in_window;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt   <= '0;
      digit_idx  <= '0;
      digits_sh  <= '0;
      dp_sh      <= '0;
      en_sh      <= '0;
      bright_sh  <= '0;
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (slot_cnt == SLOT_LAST) begin
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end
      if (eof) begin
        digits_sh <= digits_in;
        dp_sh     <= dp_in;
        en_sh     <= digit_en;
        bright_sh <= bright;
      end
      frame_done <= eof;
      an         <= ~lit;
      // Segments track the slot's digit through the guard so they settle first.
      seg        <= cur_en ? decode(cur_nib) : 7'h7F;
      dp         <= ~(cur_en & cur_dp);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seven_seg_scanner                                          |
// | Purpose  : Scoreboard bench for seven_seg_scanner (default parameters).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [3:0]  bright;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  seven_seg_scanner #(.NUM_DIGITS(4), .SLOT_W(4), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .bright     (bright),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  task automatic push(input int c, input logic [3:0] a, input logic [6:0] s,
                      input logic d, input logic f);
    exp_t e;
    e.cyc = c; e.an = a; e.seg = s; e.dp = d; e.fd = f;
    q.push_back(e);
  endtask

  // One frame of expected outputs; frame f appears in output cycles 64f+1..64f+64.
  task automatic push_frame(input int f, input logic [27:0] segs, input logic [3:0] dps,
                            input int lo, input int hi, input logic [3:0] lit_mask);
    logic [3:0] a;
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 16; i++) begin
        a = 4'hF;
        if (lit_mask[d] && i >= lo && i <= hi) a[d] = 1'b0;
        push(64*f + 1 + 16*d + i, a, segs[7*d +: 7], dps[d], (d == 3 && i == 15));
      end
    end
  endtask

  // Monitor: cycle 0 is the period following the last edge that sampled reset.
  initial begin
    logic rst_seen;
    exp_t e;
    forever begin
      @(posedge clk);
      rst_seen = reset;
      #1;
      if (rst_seen) cyc = 0;
      else          cyc = cyc + 1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        tests++;
        if (e.cyc < cyc) begin
          fails++;
          $display("FAIL missed_check: expected cycle %0d not reached, now at %0d", e.cyc, cyc);
        end else if ({an, seg, dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
          fails++;
          $display("FAIL outputs@cyc%0d: got an=%h seg=%h dp=%b fd=%b, expected an=%h seg=%h dp=%b fd=%b",
                   cyc, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
        end
      end
      tests++;
      if ($countones(~an) > 1) begin
        fails++;
        $display("FAIL anode_onehot@cyc%0d: got an=%h, expected at most one low bit", cyc, an);
      end
    end
  end

  task automatic wait_cyc(input int n);
    int g = 0;
    @(negedge clk);
    while (cyc != n && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != n) begin
      tests++;
      fails++;
      $display("FAIL wait_cyc: got cycle %0d, expected %0d", cyc, n);
    end
  endtask

  initial begin
    int g;
    reset     = 1'b1;
    digits_in = 16'h4321;
    dp_in     = 4'b0100;
    digit_en  = 4'hF;
    bright    = 4'd15;

    push(0, 4'hF, 7'h7F, 1'b1, 1'b0);
    push_frame(0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111, 1, 0, 4'b0000);
    push_frame(1, {7'h19, 7'h30, 7'h24, 7'h79}, 4'b1011, 2, 15, 4'hF);
    push_frame(2, {7'h19, 7'h30, 7'h24, 7'h79}, 4'b1011, 2, 15, 4'h0);
    push_frame(3, {7'h19, 7'h30, 7'h24, 7'h79}, 4'b1011, 2, 4, 4'hF);
    push_frame(4, {7'h7F, 7'h30, 7'h7F, 7'h79}, 4'b1011, 2, 15, 4'b0101);
    push_frame(5, {7'h19, 7'h30, 7'h24, 7'h79}, 4'b1011, 2, 15, 4'hF);
    push_frame(6, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b1011, 2, 15, 4'hF);
    push(470, 4'hD, 7'h46, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    wait_cyc(100);
    bright = 4'd0;
    wait_cyc(164);
    bright = 4'd3;
    wait_cyc(228);
    bright   = 4'd15;
    digit_en = 4'b0101;
    wait_cyc(292);
    digit_en = 4'hF;
    wait_cyc(343);
    digits_in = 16'hABCD;

    // Reset lands while digit 1 is lit; the frame that follows must be blank.
    wait_cyc(470);
    reset = 1'b1;
    push(0, 4'hF, 7'h7F, 1'b1, 1'b0);
    push_frame(0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111, 1, 0, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    wait_cyc(66);

    g = 0;
    while (q.size() > 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    while (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL unchecked: expected cycle %0d never compared, queue size %0d", q[0].cyc, q.size());
      void'(q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
